// File: rtl/result_uart_transmitter.sv
// Serial reporter for a classifier result: sends "<digit>\r\n" as three 8N1 bytes.
// The line is registered, so it goes low one cycle after i_start is accepted.
module result_uart_transmitter #(
   parameter int CLKS_PER_BIT = 5209
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       i_start,
   input  logic [3:0] i_digit,
   output logic       o_tx_serial,
   output logic       o_busy,
   output logic       o_done,
   output logic [1:0] o_dbg_state
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [2:0]       r_bit_idx;
   logic [2:0]       w_bit_nxt;
   logic [1:0]       r_byte_idx;
   logic [1:0]       w_byte_nxt;
   logic [3:0]       r_digit;
   logic [3:0]       w_digit_nxt;
   logic             r_tx;
   logic             w_tx_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_last_cnt;
   logic [2:0]       w_bit_inc;
   logic [7:0]       w_cur_byte;

   // Message content: ASCII digit (or '?' for out-of-range indices), CR, LF.
   function automatic logic [7:0] byte_for(input logic [1:0] idx, input logic [3:0] digit);
      logic [7:0] b;
      case (idx)
         2'd0:    b = (digit <= 4'd9) ? (8'h30 + {4'h0, digit}) : 8'h3F;
         2'd1:    b = 8'h0D;
         default: b = 8'h0A;
      endcase
      return b;
   endfunction

   assign w_last_cnt = (r_cnt == CNT_LAST);
   assign w_bit_inc  = r_bit_idx + 3'd1;
   assign w_cur_byte = byte_for(r_byte_idx, r_digit);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_last_cnt ? '0 : (r_cnt + CNT_W'(1));
      w_bit_nxt   = r_bit_idx;
      w_byte_nxt  = r_byte_idx;
      w_digit_nxt = r_digit;
      w_tx_nxt    = r_tx;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_cnt_nxt  = '0;
            w_bit_nxt  = 3'd0;
            w_byte_nxt = 2'd0;
            w_tx_nxt   = 1'b1;
            if (i_start) begin
               w_state_nxt = START_BIT;
               w_digit_nxt = i_digit;
               w_tx_nxt    = 1'b0;
            end
         end
         START_BIT: begin
            w_tx_nxt = 1'b0;
            if (w_last_cnt) begin
               w_state_nxt = DATA_BITS;
               w_bit_nxt   = 3'd0;
               w_tx_nxt    = w_cur_byte[0];
            end
         end
         DATA_BITS: begin
            w_tx_nxt = w_cur_byte[r_bit_idx];
            if (w_last_cnt) begin
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = STOP_BIT;
                  w_bit_nxt   = 3'd0;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_bit_nxt = w_bit_inc;
                  w_tx_nxt  = w_cur_byte[w_bit_inc];
               end
            end
         end
         STOP_BIT: begin
            w_tx_nxt = 1'b1;
            if (w_last_cnt) begin
               if (r_byte_idx == 2'd2) begin
                  w_state_nxt = IDLE;
                  w_byte_nxt  = 2'd0;
                  w_done_nxt  = 1'b1;
               end else begin
                  // Next byte's start bit follows with no idle gap.
                  w_state_nxt = START_BIT;
                  w_byte_nxt  = r_byte_idx + 2'd1;
                  w_tx_nxt    = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_bit_idx  <= 3'd0;
         r_byte_idx <= 2'd0;
         r_digit    <= 4'd0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_byte_idx <= w_byte_nxt;
         r_digit    <= w_digit_nxt;
         r_tx       <= w_tx_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign o_tx_serial = r_tx;
   assign o_busy      = (r_state != IDLE);
   assign o_done      = r_done;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_result_uart_transmitter.sv
// Directed bench for result_uart_transmitter: vector table of digits plus
// hand-written sequences for retrigger, held start, reset abort and full-rate bit timing.
module tb_result_uart_transmitter;

   localparam int CPB = 4;
   localparam int BIG = 5209;
   localparam int MSG = 30 * CPB;

   logic       clk;
   logic       resetn;
   logic       i_start;
   logic [3:0] i_digit;
   logic       o_tx_serial;
   logic       o_busy;
   logic       o_done;
   logic [1:0] o_dbg_state;

   logic       i_start_b;
   logic [3:0] i_digit_b;
   logic       tx_b;
   logic       busy_b;
   logic       done_b;
   logic [1:0] st_b;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [3:0] digit;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
   } vec_t;

   vec_t vecs[6];

   result_uart_transmitter #(.CLKS_PER_BIT(CPB)) u_dut (
      .clk(clk), .resetn(resetn), .i_start(i_start), .i_digit(i_digit),
      .o_tx_serial(o_tx_serial), .o_busy(o_busy), .o_done(o_done), .o_dbg_state(o_dbg_state)
   );

   result_uart_transmitter #(.CLKS_PER_BIT(BIG)) u_big (
      .clk(clk), .resetn(resetn), .i_start(i_start_b), .i_digit(i_digit_b),
      .o_tx_serial(tx_b), .o_busy(busy_b), .o_done(done_b), .o_dbg_state(st_b)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Driver + monitor for one message at CPB. Entered at the negedge of an IDLE
   // cycle; returns at the negedge of the o_done cycle with i_start untouched if hold.
   task automatic run_msg(input logic [3:0] digit, input bit hold, input int glitch_at,
                          input logic [3:0] glitch_digit, input logic [7:0] e0,
                          input logic [7:0] e1, input logic [7:0] e2, input string tag);
      logic       line [MSG];
      logic [7:0] got [3];
      int         busy_cnt;
      int         early_done;
      int         frame_err;
      logic       v;
      chk({tag, "_idle_tx"}, 32'(o_tx_serial), 32'd1);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      i_digit = digit;
      i_start = 1'b1;
      @(negedge clk);
      busy_cnt   = 0;
      early_done = 0;
      for (int k = 0; k < MSG; k++) begin
         line[k] = o_tx_serial;
         if (o_busy) busy_cnt++;
         if (o_done) early_done++;
         if (!hold) i_start = (k == glitch_at);
         if (k == glitch_at) i_digit = glitch_digit;
         @(negedge clk);
      end
      chk({tag, "_done_pulse"}, 32'(o_done), 32'd1);
      chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
      chk({tag, "_tx_end"}, 32'(o_tx_serial), 32'd1);
      chk({tag, "_busy_len"}, 32'(busy_cnt), 32'(MSG));
      chk({tag, "_early_done"}, 32'(early_done), 32'd0);
      frame_err = 0;
      for (int s = 0; s < 30; s++) begin
         v = line[s * CPB];
         for (int j = 1; j < CPB; j++)
            if (line[s * CPB + j] !== v) frame_err++;
         if (s % 10 == 0) begin
            if (v !== 1'b0) frame_err++;
         end else if (s % 10 == 9) begin
            if (v !== 1'b1) frame_err++;
         end else begin
            got[s / 10][s % 10 - 1] = v;
         end
      end
      chk({tag, "_framing"}, 32'(frame_err), 32'd0);
      for (int b = 0; b < 3; b++)
         chk($sformatf("%s_byte%0d", tag, b), 32'(got[b]), 32'(exp_q.pop_front()));
   endtask

   initial begin
      int   busy_seen;
      int   low_seen;
      int   run;
      logic prev;
      logic samp [10];
      logic [7:0] dec;
      int   runs[$];
      int   exp_runs[5];

      vecs[0] = '{4'd0,  8'h30, 8'h0D, 8'h0A};
      vecs[1] = '{4'd7,  8'h37, 8'h0D, 8'h0A};
      vecs[2] = '{4'd9,  8'h39, 8'h0D, 8'h0A};
      vecs[3] = '{4'd10, 8'h3F, 8'h0D, 8'h0A};
      vecs[4] = '{4'd12, 8'h3F, 8'h0D, 8'h0A};
      vecs[5] = '{4'd15, 8'h3F, 8'h0D, 8'h0A};

      resetn    = 1'b0;
      i_start   = 1'b1;
      i_digit   = 4'd6;
      i_start_b = 1'b0;
      i_digit_b = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(o_tx_serial), 32'd1);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      chk("rst_state", 32'(o_dbg_state), 32'd0);
      i_start = 1'b0;
      resetn  = 1'b1;

      // First vector starts on the first posedge after reset release.
      for (int i = 0; i < 6; i++) begin
         run_msg(vecs[i].digit, 1'b0, -1, 4'd0, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                 $sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d_done_once", i), 32'(o_done), 32'd0);
         repeat (2) @(negedge clk);
      end

      // Retrigger mid-message with a different digit: ignored, nothing queued.
      run_msg(4'd7, 1'b0, 50, 4'd3, 8'h37, 8'h0D, 8'h0A, "glitch");
      busy_seen = 0;
      low_seen  = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (o_busy) busy_seen++;
         if (!o_tx_serial) low_seen++;
      end
      chk("glitch_no_second_busy", 32'(busy_seen), 32'd0);
      chk("glitch_no_second_tx", 32'(low_seen), 32'd0);

      // i_start held high: back-to-back messages, restart accepted in the o_done cycle.
      run_msg(4'd0, 1'b1, -1, 4'd0, 8'h30, 8'h0D, 8'h0A, "hold1");
      run_msg(4'd0, 1'b1, -1, 4'd0, 8'h30, 8'h0D, 8'h0A, "hold2");
      i_start = 1'b0;
      @(negedge clk);
      chk("hold_stop_busy", 32'(o_busy), 32'd0);
      chk("hold_stop_done", 32'(o_done), 32'd0);

      // Reset during the second byte's data bits aborts the message.
      i_digit = 4'd5;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (51) @(negedge clk);
      chk("abort_pre_state", 32'(o_dbg_state), 32'd2);
      #2 resetn = 1'b0;
      #1;
      chk("abort_tx", 32'(o_tx_serial), 32'd1);
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_state", 32'(o_dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      chk("abort_hold_tx", 32'(o_tx_serial), 32'd1);
      resetn    = 1'b1;
      busy_seen = 0;
      low_seen  = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (o_busy) busy_seen++;
         if (!o_tx_serial) low_seen++;
      end
      chk("abort_idle_busy", 32'(busy_seen), 32'd0);
      chk("abort_idle_tx", 32'(low_seen), 32'd0);

      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      run_msg(4'd4, 1'b0, -1, 4'd0, 8'h34, 8'h0D, 8'h0A, "after_rst");
      i_start = 1'b0;
      @(negedge clk);

      // Full-rate instance: run lengths of 0x39 framed LSB first, plus mid-bit decode.
      exp_runs = '{BIG, BIG, 2 * BIG, 3 * BIG, 2 * BIG};
      i_digit_b = 4'd9;
      i_start_b = 1'b1;
      @(negedge clk);
      i_start_b = 1'b0;
      prev = tx_b;
      run  = 0;
      for (int k = 0; k <= 9 * BIG + BIG / 2; k++) begin
         if (tx_b === prev) begin
            run++;
         end else begin
            runs.push_back(run);
            prev = tx_b;
            run  = 1;
         end
         for (int i = 0; i < 10; i++)
            if (k == i * BIG + BIG / 2) samp[i] = tx_b;
         @(negedge clk);
      end
      chk("big_run_count", 32'(runs.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < runs.size()) chk($sformatf("big_run%0d", i), 32'(runs[i]), 32'(exp_runs[i]));
      for (int i = 0; i < 8; i++) dec[i] = samp[i + 1];
      chk("big_start", 32'(samp[0]), 32'd0);
      chk("big_stop", 32'(samp[9]), 32'd1);
      chk("big_byte", 32'(dec), 32'h39);
      chk("big_busy", 32'(busy_b), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
